butterfly_unit_cfg: RTL and testbench
=====================================

BUTTERFLY_UNIT_CFG -- requirements
Module: butterfly_unit_cfg

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 12, coefficient width.
REQ-002 SHALL have parameter MODULUS, default 3329, prime modulus q (q < 2^DATA_WIDTH).
REQ-003 SHALL have parameter MUL_STAGES, default 3, modular-multiplier pipeline depth (>=1).
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  input beat offered.
REQ-007 SHALL have port in_ready  output  1  block accepts beat this cycle.
REQ-008 SHALL have port mode  input  1  0 = Cooley-Tukey (NTT), 1 = Gentleman-Sande (INTT); sampled per beat.
REQ-009 SHALL have port halve  input  1  GS only: divide both results by 2 mod q; sampled per beat.
REQ-010 SHALL have port a_in  input  DATA_WIDTH  operand a.
REQ-011 SHALL have port b_in  input  DATA_WIDTH  operand b.
REQ-012 SHALL have port twiddle  input  DATA_WIDTH  twiddle w.
REQ-013 SHALL have port clear_err  input  1  synchronous clear of range_err.
REQ-014 SHALL have port out_valid  output  1  result beat present.
REQ-015 SHALL have port out_ready  input  1  downstream accepts result.
REQ-016 SHALL have port a_out  output  DATA_WIDTH  result a'.
REQ-017 SHALL have port b_out  output  DATA_WIDTH  result b'.
REQ-018 SHALL have port in_flight  output  $clog2(MUL_STAGES+3)  accepted beats not yet delivered.
REQ-019 SHALL have port range_err  output  1  sticky: an accepted operand was >= MODULUS.

Function
REQ-020 SHALL compute, for mode=0: a' = (a + b*w) mod q, b' = (a - b*w) mod q; halve ignored.
REQ-021 SHALL compute, for mode=1: a' = (a + b) mod q, b' = ((a - b) * w) mod q; if halve=1 each result further multiplied by 2^-1 mod q (x even: x>>1, else (x+q)>>1).
REQ-022 SHALL produce bit-exact fully reduced results in [0, q-1] for all operands in [0, q-1]; no intermediate overflow (product width 2*DATA_WIDTH).
REQ-023 SHALL have fixed latency L = MUL_STAGES + 2 cycles from accepting handshake to out_valid, for both modes, absent stalls.
REQ-024 SHALL pipeline as: stage 1 GS add/sub (CT: operand align), MUL_STAGES multiply+reduce, final stage CT add/sub or GS halve, registered outputs.
REQ-025 SHALL carry mode and halve with each beat; mixed-mode back-to-back beats SHALL each use their own mode.
REQ-026 SHALL accept one beat per cycle when in_valid && in_ready (full throughput).
REQ-027 SHALL drive in_ready = !(out_valid && !out_ready); when low, entire pipeline stalls, no stage advances.
REQ-028 SHALL hold a_out, b_out, out_valid stable while out_valid && !out_ready.
REQ-029 SHALL never drop, duplicate, or reorder beats; bubbles propagate as invalid stages.
REQ-030 SHALL update in_flight: +1 on input handshake, -1 on output handshake, unchanged if both or neither same cycle.
REQ-031 SHALL set range_err on accepted beat with a_in, b_in or twiddle >= MODULUS; result for such beat is don't-care but beat still flows.
REQ-032 SHALL give set priority over clear_err when both occur same cycle.

Reset
REQ-033 SHALL on rst_n low immediately clear out_valid, all stage valids, in_flight, range_err, a_out, b_out to 0, mid-operation included; in-flight beats discarded.
REQ-034 SHALL drive in_ready = 1 during and after reset.

Verification
REQ-035 CT: a=5,b=7,w=17, out_ready=1 -> after L=5 cycles a'=124, b'=3215.
REQ-036 GS: a=5,b=7,w=17,halve=0 -> a'=12, b'=3295; same with halve=1 -> a'=6, b'=3312.
REQ-037 Boundary CT: a=b=w=3328 -> a'=0, b'=3327; a=0,b=0,w=0 -> a'=0,b'=0.
REQ-038 Backpressure: stream 10 random beats, out_ready low 3 cycles mid-stream -> in_ready low same cycles, outputs held, all 10 results correct, in order; in_flight returns to 0.
REQ-039 Reset mid-stream with 4 beats in flight -> out_valid=0, in_flight=0 same cycle; next beat after release correct at latency L.
REQ-040 Range: accept b_in=3329 -> range_err=1 next cycle, stays set until clear_err; clear_err with simultaneous new error -> stays 1.

Source files
------------

// File: rtl/butterfly_unit_cfg.sv
// Configurable NTT/INTT butterfly over Z_q.
// Pipeline: stage 1 (GS add/sub or CT operand align), MUL_STAGES of
// modular multiply + reduce, then a final stage (CT add/sub or GS halve)
// feeding the output registers. Fixed latency MUL_STAGES + 2.
//
// Handshake: a beat moves on a clock edge only when valid && ready are
// both high on that edge. in_ready = !(out_valid && !out_ready). When
// in_ready is low the whole pipeline freezes, so the output beat and
// every stage hold their contents until the consumer takes the output.
module butterfly_unit_cfg #(
  parameter int DATA_WIDTH = 12,
  parameter int MODULUS    = 3329,
  parameter int MUL_STAGES = 3
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic                              mode,
  input  logic                              halve,
  input  logic [DATA_WIDTH-1:0]             a_in,
  input  logic [DATA_WIDTH-1:0]             b_in,
  input  logic [DATA_WIDTH-1:0]             twiddle,
  input  logic                              clear_err,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_WIDTH-1:0]             a_out,
  output logic [DATA_WIDTH-1:0]             b_out,
  output logic [$clog2(MUL_STAGES+3)-1:0]   in_flight,
  output logic                              range_err
);

  localparam int W    = DATA_WIDTH;
  localparam int PW   = 2 * DATA_WIDTH;
  localparam int CW   = $clog2(MUL_STAGES + 3);
  localparam int LAST = MUL_STAGES - 1;

  localparam logic [W-1:0]  Q  = W'(MODULUS);
  localparam logic [W:0]    Q1 = (W + 1)'(MODULUS);
  localparam logic [PW-1:0] QP = PW'(MODULUS);

  // (x + y) mod q for x, y in [0, q-1]
  function automatic logic [W-1:0] mod_add(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= Q1) s = s - Q1;
    return s[W-1:0];
  endfunction

  // (x - y) mod q for x, y in [0, q-1]
  function automatic logic [W-1:0] mod_sub(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] d;
    if (x >= y) d = {1'b0, x} - {1'b0, y};
    else        d = {1'b0, x} + Q1 - {1'b0, y};
    return d[W-1:0];
  endfunction

  // x * 2^-1 mod q: odd values borrow one q to become even first
  function automatic logic [W-1:0] mod_half(input logic [W-1:0] x);
    logic [W:0] h;
    h = x[0] ? ({1'b0, x} + Q1) : {1'b0, x};
    h = h >> 1;
    return h[W-1:0];
  endfunction

  logic in_fire, out_fire, adv, err_set;

  // Stage 1 registers
  logic         s1_valid, s1_mode, s1_halve;
  logic [W-1:0] s1_x, s1_y, s1_w;
  logic [W-1:0] s1_x_d, s1_y_d;

  // Multiplier stages
  logic [MUL_STAGES-1:0] m_valid, m_mode, m_halve;
  logic [W-1:0]          m_x   [MUL_STAGES];
  logic [PW-1:0]         m_p   [MUL_STAGES];
  logic [PW-1:0]         m_p_d [MUL_STAGES];

  // Final stage
  logic [W-1:0] f_x, f_r, f_a, f_b;

  // Global stall and handshake decode
  always_comb begin
    in_ready = !(out_valid && !out_ready);
    adv      = in_ready;
    in_fire  = in_valid && in_ready;
    out_fire = out_valid && out_ready;
    err_set  = in_fire && ((a_in >= Q) || (b_in >= Q) || (twiddle >= Q));
  end

  // Stage 1 datapath: GS forms sum/difference, CT passes operands through
  always_comb begin
    s1_x_d = a_in;
    s1_y_d = b_in;
    if (mode) begin
      s1_x_d = mod_add(a_in, b_in);
      s1_y_d = mod_sub(a_in, b_in);
    end
  end

  // Stage 1 register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_mode  <= 1'b0;
      s1_halve <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_w     <= '0;
    end else if (adv) begin
      s1_valid <= in_fire;
      s1_mode  <= mode;
      s1_halve <= halve;
      s1_x     <= s1_x_d;
      s1_y     <= s1_y_d;
      s1_w     <= twiddle;
    end
  end

  // Multiplier datapath: full-width product, reduced entering the last stage
  always_comb begin
    for (int i = 0; i < MUL_STAGES; i++) m_p_d[i] = '0;
    m_p_d[0] = {{W{1'b0}}, s1_y} * {{W{1'b0}}, s1_w};
    for (int i = 1; i < MUL_STAGES; i++) m_p_d[i] = m_p[i-1];
    m_p_d[LAST] = m_p_d[LAST] % QP;
  end

  // Multiplier stage registers with per-beat mode/halve sideband
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= '0;
      m_mode  <= '0;
      m_halve <= '0;
      for (int i = 0; i < MUL_STAGES; i++) begin
        m_x[i] <= '0;
        m_p[i] <= '0;
      end
    end else if (adv) begin
      m_valid[0] <= s1_valid;
      m_mode[0]  <= s1_mode;
      m_halve[0] <= s1_halve;
      m_x[0]     <= s1_x;
      for (int i = 1; i < MUL_STAGES; i++) begin
        m_valid[i] <= m_valid[i-1];
        m_mode[i]  <= m_mode[i-1];
        m_halve[i] <= m_halve[i-1];
        m_x[i]     <= m_x[i-1];
      end
      for (int i = 0; i < MUL_STAGES; i++) m_p[i] <= m_p_d[i];
    end
  end

  // Final stage: CT add/sub around the product, or GS optional halving
  always_comb begin
    f_x = m_x[LAST];
    f_r = m_p[LAST][W-1:0];
    f_a = f_x;
    f_b = f_r;
    if (!m_mode[LAST]) begin
      f_a = mod_add(f_x, f_r);
      f_b = mod_sub(f_x, f_r);
    end else if (m_halve[LAST]) begin
      f_a = mod_half(f_x);
      f_b = mod_half(f_r);
    end
  end

  // Output registers, frozen while the consumer back-pressures
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      a_out     <= '0;
      b_out     <= '0;
    end else if (adv) begin
      out_valid <= m_valid[LAST];
      if (m_valid[LAST]) begin
        a_out <= f_a;
        b_out <= f_b;
      end
    end
  end

  // Occupancy counter: accepted beats not yet delivered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_flight <= '0;
    end else begin
      case ({in_fire, out_fire})
        2'b10:   in_flight <= in_flight + CW'(1);
        2'b01:   in_flight <= in_flight - CW'(1);
        default: in_flight <= in_flight;
      endcase
    end
  end

  // Sticky range error; a new error wins over a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         range_err <= 1'b0;
    else if (err_set)   range_err <= 1'b1;
    else if (clear_err) range_err <= 1'b0;
  end

endmodule

// File: tb/tb_butterfly_unit_cfg.sv
// Bench for butterfly_unit_cfg: directed beats with literal results,
// a modular-arithmetic reference model, and one negedge compare process.
module tb_butterfly_unit_cfg;

  localparam int W  = 12;
  localparam int Q  = 3329;
  localparam int M  = 3;
  localparam int L  = M + 2;
  localparam int CW = $clog2(M + 3);

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, mode, halve, clear_err;
  logic [W-1:0]  a_in, b_in, twiddle;
  logic          out_valid, out_ready;
  logic [W-1:0]  a_out, b_out;
  logic [CW-1:0] in_flight;
  logic          range_err;

  always #5 clk = ~clk;

  butterfly_unit_cfg #(.DATA_WIDTH(W), .MODULUS(Q), .MUL_STAGES(M)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .halve(halve), .a_in(a_in), .b_in(b_in), .twiddle(twiddle),
    .clear_err(clear_err), .out_valid(out_valid), .out_ready(out_ready),
    .a_out(a_out), .b_out(b_out), .in_flight(in_flight), .range_err(range_err)
  );

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- scoreboard state ----------------
  typedef struct {
    int   a;
    int   b;
    logic dc;
    logic has_lit;
    int   la;
    int   lb;
    int   acc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   model_flight = 0;
  logic model_err = 1'b0;
  logic lat_exact = 1'b1;
  logic stalled_prev = 1'b0;
  logic [W-1:0] prev_a, prev_b;
  logic lit_has = 1'b0;
  int   lit_a = 0, lit_b = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: butterfly results straight from modular arithmetic
  function automatic void model(input int a, input int b, input int w,
                                input logic md, input logic hv,
                                output int ea, output int eb);
    int p, inv2;
    inv2 = (Q + 1) / 2;
    if (!md) begin
      p  = (b * w) % Q;
      ea = (a + p) % Q;
      eb = ((a - p) % Q + Q) % Q;
    end else begin
      ea = (a + b) % Q;
      eb = ((((a - b) % Q + Q) % Q) * w) % Q;
      if (hv) begin
        ea = (ea * inv2) % Q;
        eb = (eb * inv2) % Q;
      end
    end
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    exp_t e;
    int   ea, eb;
    if (!rst_n) begin
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_flight", 32'(in_flight), 32'd0);
      chk("rst_range_err", 32'(range_err), 32'd0);
      chk("rst_a_out", 32'(a_out), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      exp_q.delete();
      model_flight = 0;
      model_err    = 1'b0;
      stalled_prev = 1'b0;
    end else begin
      chk("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
      chk("in_flight", 32'(in_flight), 32'(model_flight));
      chk("range_err", 32'(range_err), 32'(model_err));
      if (stalled_prev) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_a", 32'(a_out), 32'(prev_a));
        chk("hold_b", 32'(b_out), 32'(prev_b));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          if (!e.dc) begin
            chk("a_out", 32'(a_out), 32'(e.a));
            chk("b_out", 32'(b_out), 32'(e.b));
          end
          if (e.has_lit) begin
            chk("lit_a", 32'(a_out), 32'(e.la));
            chk("lit_b", 32'(b_out), 32'(e.lb));
          end
          if (lat_exact) chk("latency", 32'(cyc - e.acc), 32'(L));
        end
      end
      if (in_valid && in_ready) begin
        model(int'(a_in), int'(b_in), int'(twiddle), mode, halve, ea, eb);
        e.a = ea; e.b = eb;
        e.dc = (int'(a_in) >= Q) || (int'(b_in) >= Q) || (int'(twiddle) >= Q);
        e.has_lit = lit_has; e.la = lit_a; e.lb = lit_b;
        e.acc = cyc;
        exp_q.push_back(e);
      end
      // model state after the coming edge
      if (in_valid && in_ready && !(out_valid && out_ready)) model_flight++;
      else if (!(in_valid && in_ready) && out_valid && out_ready) model_flight--;
      if (in_valid && in_ready && e.dc) model_err = 1'b1;
      else if (clear_err) model_err = 1'b0;
      stalled_prev = out_valid && !out_ready;
      prev_a = a_out;
      prev_b = b_out;
    end
  end

  // ---------------- driver tasks (start/end at posedge + #1) ----------------
  task automatic send(input int a, input int b, input int w, input logic md,
                      input logic hv, input logic hl, input int la, input int lb);
    bit ok;
    a_in = a[W-1:0]; b_in = b[W-1:0]; twiddle = w[W-1:0];
    mode = md; halve = hv;
    lit_has = hl; lit_a = la; lit_b = lb;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lit_has  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      if (exp_q.size() == 0 && !out_valid) done = 1'b1;
      else idle(1);
    end
    if (!done) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clear_err = 1'b0;
    mode = 1'b0; halve = 1'b0; a_in = '0; b_in = '0; twiddle = '0;
    idle(3);
    rst_n = 1'b1;
    idle(1);

    // directed, back to back, mixed modes
    send(5, 7, 17, 1'b0, 1'b0, 1'b1, 124, 3215);
    send(5, 7, 17, 1'b1, 1'b0, 1'b1, 12, 3295);
    send(5, 7, 17, 1'b1, 1'b1, 1'b1, 6, 3312);
    send(3328, 3328, 3328, 1'b0, 1'b0, 1'b1, 0, 3327);
    send(0, 0, 0, 1'b0, 1'b0, 1'b1, 0, 0);
    send(5, 7, 17, 1'b0, 1'b1, 1'b1, 124, 3215);
    send(100, 200, 300, 1'b0, 1'b0, 1'b1, 178, 22);
    send(3328, 0, 3328, 1'b1, 1'b1, 1'b0, 0, 0);
    drain();

    // back-pressure: 10 random beats, out_ready low 3 cycles mid-stream
    lat_exact = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++)
          send(int'($urandom_range(0, Q - 1)), int'($urandom_range(0, Q - 1)),
               int'($urandom_range(0, Q - 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'b0, 0, 0);
      end
      begin
        idle(7);
        out_ready = 1'b0;
        idle(3);
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_in_flight", 32'(in_flight), 32'd0);
    lat_exact = 1'b1;

    // reset with 4 beats in flight
    send(1, 2, 3, 1'b0, 1'b0, 1'b0, 0, 0);
    send(4, 5, 6, 1'b1, 1'b0, 1'b0, 0, 0);
    send(7, 8, 9, 1'b1, 1'b1, 1'b0, 0, 0);
    send(10, 11, 12, 1'b0, 1'b0, 1'b0, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_flight", 32'(in_flight), 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    send(100, 200, 300, 1'b0, 1'b0, 1'b1, 178, 22);
    drain();

    // range error: set, sticky, set beats simultaneous clear, then clear
    send(1, 3329, 1, 1'b0, 1'b0, 1'b0, 0, 0);
    #1;
    chk("range_set", 32'(range_err), 32'd1);
    idle(3);
    clear_err = 1'b1;
    send(1, 1, 4000, 1'b0, 1'b0, 1'b0, 0, 0);
    clear_err = 1'b0;
    #1;
    chk("range_set_over_clear", 32'(range_err), 32'd1);
    idle(2);
    clear_err = 1'b1;
    idle(1);
    clear_err = 1'b0;
    #1;
    chk("range_cleared", 32'(range_err), 32'd0);
    send(5, 7, 17, 1'b1, 1'b1, 1'b1, 6, 3312);
    drain();

    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
